// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, parser states and the queued key-event type.
package ps2_pkg;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: show-ahead key-event queue; push on full is accepted only alongside a pop.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK_clk_i,
    input  logic                   RST_rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  evt_t                   din,
    output evt_t                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    evt_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK_clk_i) begin
        if (RST_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK_clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: folds E0/F0 prefixes into key events, queues them and flags
// framing, overrun, prefix-timeout and queue-overflow conditions.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLK_clk_i,
    input  logic       RST_rst_i,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_start_bit_i,
    output logic       rx_en_o,
    output logic       evt_valid_o,
    output logic [7:0] evt_code_o,
    output logic       evt_break_o,
    output logic       evt_ext_o,
    input  logic       evt_pop_i,
    output logic       err_o,
    output logic       ovf_o,
    input  logic       ovf_clr_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    ps2_state_t     state, state_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic [CW-1:0]  count;
    logic           tmo, ovr, pfx, push, err_nxt, full, empty;
    evt_t           evt_in, evt_head;

    assign ovr = rx_data_i == SC_OVR0 || rx_data_i == SC_OVR1;
    assign pfx = rx_data_i == SC_EXT || rx_data_i == SC_BRK;
    // A byte on the terminal-count cycle wins over the timeout.
    assign tmo = state != ST_IDLE && !rx_done_tick_i && tmo_cnt == TW'(TIMEOUT_CYC - 1);

    always_ff @(posedge CLK_clk_i) begin
        if (RST_rst_i) state <= ST_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_done_tick_i) begin
            if (rx_start_bit_i) state_nxt = ST_IDLE;
            else case (state)
                ST_IDLE: state_nxt = rx_data_i == SC_EXT ? ST_E0 : rx_data_i == SC_BRK ? ST_F0 : ST_IDLE;
                ST_E0:   state_nxt = rx_data_i == SC_BRK ? ST_E0F0 : rx_data_i == SC_EXT ? ST_E0 : ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo) state_nxt = ST_IDLE;
    end

    always_comb begin
        push    = 1'b0;
        err_nxt = tmo;
        evt_in  = {state == ST_E0 || state == ST_E0F0, state == ST_F0 || state == ST_E0F0, rx_data_i};
        if (rx_done_tick_i) begin
            if (rx_start_bit_i || ovr) err_nxt = 1'b1;
            else if (state == ST_F0 || state == ST_E0F0) begin
                err_nxt = pfx;
                push    = !pfx;
            end else push = !pfx;
        end
    end

    always_ff @(posedge CLK_clk_i) begin
        if (RST_rst_i || rx_done_tick_i || state_nxt == ST_IDLE) tmo_cnt <= '0;
        else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge CLK_clk_i) begin
        if (RST_rst_i) begin
            err_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            err_o <= err_nxt;
            ovf_o <= (push & full & ~evt_pop_i) | (ovf_o & ~ovf_clr_i);
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK_clk_i (CLK_clk_i),
        .RST_rst_i (RST_rst_i),
        .push      (push),
        .pop       (evt_pop_i),
        .din       (evt_in),
        .dout      (evt_head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign rx_en_o     = ~RST_rst_i & (count != CW'(FIFO_DEPTH));
    assign evt_valid_o = ~empty;
    assign {evt_ext_o, evt_break_o, evt_code_o} = evt_head;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed and random byte streams against a prefix-flag model,
// with a negedge monitor consuming expected events and error pulses.
module tb_ps2_kbd_ctrl;
    localparam int D   = 4;
    localparam int TMO = 16;

    logic       CLK_clk_i = 1'b0;
    logic       RST_rst_i = 1'b1;
    logic       rx_done_tick_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_start_bit_i = 1'b0;
    logic       evt_pop_i = 1'b0;
    logic       ovf_clr_i = 1'b0;
    logic       rx_en_o, evt_valid_o, evt_break_o, evt_ext_o, err_o, ovf_o;
    logic [7:0] evt_code_o;

    int         n_chk = 0, n_fail = 0, ncyc = 0;
    bit         mon_en = 1'b0;
    logic [9:0] exp_evt[$];
    int         exp_err[$];
    bit         p_ext = 1'b0, p_brk = 1'b0, mov = 1'b0;
    int         age = 0, mcount = 0;

    always #5 CLK_clk_i = ~CLK_clk_i;

    ps2_kbd_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYC(TMO)) dut (
        .CLK_clk_i      (CLK_clk_i),
        .RST_rst_i      (RST_rst_i),
        .rx_done_tick_i (rx_done_tick_i),
        .rx_data_i      (rx_data_i),
        .rx_start_bit_i (rx_start_bit_i),
        .rx_en_o        (rx_en_o),
        .evt_valid_o    (evt_valid_o),
        .evt_code_o     (evt_code_o),
        .evt_break_o    (evt_break_o),
        .evt_ext_o      (evt_ext_o),
        .evt_pop_i      (evt_pop_i),
        .err_o          (err_o),
        .ovf_o          (ovf_o),
        .ovf_clr_i      (ovf_clr_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the same edge.
    task automatic step(input bit tick, input logic [7:0] d, input bit sb, input bit pop, input bit clr, input bit rst);
        bit         want_push, do_push, do_pop, err;
        logic [9:0] ev;
        rx_done_tick_i = tick;
        rx_data_i      = d;
        rx_start_bit_i = sb;
        evt_pop_i      = pop;
        ovf_clr_i      = clr;
        RST_rst_i      = rst;
        @(posedge CLK_clk_i);
        want_push = 1'b0;
        err       = 1'b0;
        ev        = '0;
        if (rst) begin
            p_ext = 1'b0; p_brk = 1'b0; age = 0; mcount = 0; mov = 1'b0;
            exp_evt.delete();
        end else begin
            if (tick) begin
                age = 0;
                if (sb || d == 8'h00 || d == 8'hFF) begin
                    err = 1'b1; p_ext = 1'b0; p_brk = 1'b0;
                end else if (d == 8'hE0 || d == 8'hF0) begin
                    if (p_brk) begin
                        err = 1'b1; p_ext = 1'b0; p_brk = 1'b0;
                    end else if (d == 8'hE0) p_ext = 1'b1;
                    else p_brk = 1'b1;
                end else begin
                    want_push = 1'b1;
                    ev = {p_ext, p_brk, d};
                    p_ext = 1'b0; p_brk = 1'b0;
                end
            end else if (p_ext || p_brk) begin
                age++;
                if (age == TMO) begin
                    err = 1'b1; p_ext = 1'b0; p_brk = 1'b0; age = 0;
                end
            end
            do_pop  = pop && mcount > 0;
            do_push = want_push && (mcount < D || do_pop);
            mcount  = mcount + int'(do_push) - int'(do_pop);
            if (do_push) exp_evt.push_back(ev);
            mov = (want_push && !do_push) ? 1'b1 : clr ? 1'b0 : mov;
            if (err) exp_err.push_back(ncyc + 1);
        end
        #1;
    endtask

    task automatic rx(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge CLK_clk_i) begin
        logic [9:0] head;
        bit         e;
        if (mon_en) begin
            ncyc++;
            head = exp_evt.size() != 0 ? exp_evt[0] : 10'h000;
            chk("evt_valid", evt_valid_o, exp_evt.size() != 0);
            chk("evt_head", {evt_ext_o, evt_break_o, evt_code_o}, head);
            e = exp_err.size() != 0 && exp_err[0] == ncyc;
            if (e) void'(exp_err.pop_front());
            chk("err_o", err_o, e);
            chk("ovf_o", ovf_o, mov);
            chk("rx_en_o", rx_en_o, !RST_rst_i && mcount != D);
            if (evt_pop_i && evt_valid_o && exp_evt.size() != 0) void'(exp_evt.pop_front());
        end
    end

    initial begin
        int r, k;
        logic [7:0] d;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", evt_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_rx_en", rx_en_o, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(1);
        chk("idle_rx_en", rx_en_o, 1);

        rx(8'h1C);
        chk("make_valid", evt_valid_o, 1);
        chk("make_evt", {evt_ext_o, evt_break_o, evt_code_o}, 10'h01C);
        chk("make_err", err_o, 0);
        pop1();
        chk("pop_valid", evt_valid_o, 0);
        chk("pop_code", evt_code_o, 0);

        rx(8'hE0); rx(8'hF0); rx(8'h75);
        chk("ext_brk_evt", {evt_ext_o, evt_break_o, evt_code_o}, 10'h375);
        pop1();
        chk("ext_brk_once", evt_valid_o, 0);
        rx(8'hF0); rx(8'hE0);
        chk("f0_e0_err", err_o, 1);
        chk("f0_e0_noevt", evt_valid_o, 0);

        rx(8'hE0);
        idle(TMO - 1);
        chk("tmo_early", err_o, 0);
        idle(1);
        chk("tmo_err", err_o, 1);
        rx(8'h75);
        chk("after_tmo_evt", {evt_ext_o, evt_break_o, evt_code_o}, 10'h075);
        pop1();

        step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_err", err_o, 1);
        chk("start_noevt", evt_valid_o, 0);
        rx(8'h00);
        chk("ovr_err", err_o, 1);
        chk("ovr_noevt", evt_valid_o, 0);

        for (int i = 0; i < 4; i++) rx(8'h10 + 8'(i));
        chk("full_rx_en", rx_en_o, 0);
        chk("full_ovf", ovf_o, 0);
        rx(8'h14);
        chk("drop_ovf", ovf_o, 1);
        step(1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("full_pp_head", evt_code_o, 8'h11);
        chk("full_pp_rx_en", rx_en_o, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", ovf_o, 0);
        for (int i = 0; i < 4; i++) pop1();
        chk("drained", evt_valid_o, 0);

        rx(8'h22); rx(8'hE0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", evt_valid_o, 0);
        chk("mid_rst_code", evt_code_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_rx_en", rx_en_o, 0);
        rx(8'h1C);
        chk("post_rst_evt", {evt_ext_o, evt_break_o, evt_code_o}, 10'h01C);
        pop1();

        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            else if (r < 10) begin
                k = $urandom_range(1, TMO + 2);
                for (int i = 0; i < k; i++)
                    step(1'b0, 8'h00, 1'b0, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
            end else begin
                k = $urandom_range(0, 9);
                d = k == 0 ? 8'hE0 : k == 1 ? 8'hF0 : k == 2 ? 8'h00 : k == 3 ? 8'hFF : 8'($urandom);
                step($urandom_range(0, 1) == 1, d, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 1'b0);
            end
        end

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("end_err_queue", exp_err.size(), 0);
        for (int i = 0; i < D && mcount > 0; i++) pop1();
        idle(1);
        chk("end_evt_queue", exp_evt.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
